lab_1_switch_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the lab 1 2-to-1 multiplexer. It takes the raw board slide switches (x, y, s), synchronises each to the system clock, and rejects contact bounce. It drives clean, stable levels into the mux data and select inputs, plus one-cycle edge pulses for later lab stages. Each channel is independent and identical.

---
 rtl/lab_1_switch_debounce.sv | 78 +++++++
 tb/tb_lab_1_switch_debounce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lab_1_switch_debounce.sv
// Switch conditioning ahead of the lab 1 mux: per-channel two-flop synchroniser,
// persistence-counter debounce, and registered one-cycle rise/fall strobes.
module lab_1_switch_debounce #(
  parameter int WIDTH   = 3,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  // Counter value on the edge that accepts a new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            out_q, out_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // sw_in is asynchronous to clk; only sync2 may be observed by the debounce logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let both synchroniser stages sample the
      // pre-edge values, so sync2 really lags sync1 by one cycle.
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted before the loop, so no
    // path leaves a signal unassigned and no latch is inferred.
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == out_q[i]) begin
        // Matching level: abandon any pending transition.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        out_d[i]  = sync2_q[i];
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sw_out  = out_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;

endmodule

// File: tb/tb_lab_1_switch_debounce.sv
// Scoreboard bench for lab_1_switch_debounce with CNT_MAX = 4, WIDTH = 3:
// stimulus queues expected output events, a monitor pops and compares them.
module tb_lab_1_switch_debounce;

  localparam int W  = 3;
  localparam int CM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out, sw_rise, sw_fall;

  lab_1_switch_debounce #(.WIDTH(W), .CNT_MAX(CM)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  // Number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           edge_no;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change 2 time units after a falling edge, clear of both the monitor
  // sample point and the next rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // A step driven now meets setup for edge cyc+1, so it is accepted at cyc+1+1+CM.
  task automatic expect_step(input string name, input logic [W-1:0] o,
                             input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t e;
    e.edge_no = cyc + 2 + CM;
    e.out     = o;
    e.rise    = r;
    e.fall    = f;
    e.name    = name;
    sb.push_back(e);
  endtask

  // Monitor: any strobe or level change is an output event and must match the
  // head of the scoreboard, including the edge on which it appears.
  initial begin
    logic [W-1:0] prev_out;
    exp_t         e;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_out = sw_out;
      end else begin
        while (sb.size() > 0 && sb[0].edge_no < cyc) begin
          e = sb.pop_front();
          n_checks++;
          $display("FAIL %s: no output event by edge %0d, expected at edge %0d",
                   e.name, cyc, e.edge_no);
        end
        if (sw_rise != '0 || sw_fall != '0 || sw_out != prev_out) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event at edge %0d: out=%b rise=%b fall=%b, required none",
                     cyc, sw_out, sw_rise, sw_fall);
          end else begin
            e = sb.pop_front();
            check({e.name, "_edge"}, cyc,     e.edge_no);
            check({e.name, "_out"},  sw_out,  e.out);
            check({e.name, "_rise"}, sw_rise, e.rise);
            check({e.name, "_fall"}, sw_fall, e.fall);
          end
        end
        prev_out = sw_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;

    // Reset values
    rst   = 1'b1;
    sw_in = '0;
    tick(2);
    check("reset_out",  sw_out,  3'b000);
    check("reset_rise", sw_rise, 3'b000);
    check("reset_fall", sw_fall, 3'b000);
    rst = 1'b0;
    tick(3);

    // Clean step on channel 0
    sw_in = 3'b001;
    expect_step("clean_step", 3'b001, 3'b001, 3'b000);
    tick(8);

    // Raise channel 1, then a 3-cycle low glitch that must be rejected
    sw_in = 3'b011;
    expect_step("ch1_up", 3'b011, 3'b010, 3'b000);
    tick(8);
    sw_in = 3'b001;
    tick(3);
    sw_in = 3'b011;
    tick(6);
    check("glitch_cnt", dut.cnt_q[1], 0);
    check("glitch_out", sw_out, 3'b011);

    // Bounce on channel 2, settling high
    sw_in = 3'b111; tick();
    sw_in = 3'b011; tick();
    sw_in = 3'b111; tick();
    sw_in = 3'b011; tick();
    sw_in = 3'b111;
    expect_step("bounce", 3'b111, 3'b100, 3'b000);
    tick(8);

    // All channels fall together, then two rise together
    sw_in = 3'b000;
    expect_step("all_fall", 3'b000, 3'b000, 3'b111);
    tick(8);
    sw_in = 3'b101;
    expect_step("simul_rise", 3'b101, 3'b101, 3'b000);
    tick(8);

    // Asynchronous reset while sw_out is all high and a rise strobe is live
    sw_in = 3'b111;
    c0 = cyc;
    expect_step("pre_reset", 3'b111, 3'b010, 3'b000);
    tick(6);
    check("pre_reset_edge_reached", cyc, c0 + 6);
    rst = 1'b1;
    #1;
    check("async_reset_out",  sw_out,  3'b000);
    check("async_reset_rise", sw_rise, 3'b000);
    check("async_reset_fall", sw_fall, 3'b000);
    tick(2);
    rst = 1'b0;
    expect_step("post_reset", 3'b111, 3'b111, 3'b000);
    tick(8);

    // Reset in the middle of a pending transition on channel 0
    sw_in = 3'b110;
    expect_step("ch0_fall", 3'b110, 3'b000, 3'b001);
    tick(8);
    sw_in = 3'b111;
    tick(3);
    check("midcount_pending_cnt", dut.cnt_q[0], 1);
    rst = 1'b1;
    #1;
    check("midcount_reset_out", sw_out, 3'b000);
    check("midcount_reset_cnt", dut.cnt_q[0], 0);
    tick(1);
    rst = 1'b0;
    expect_step("midcount_reset", 3'b111, 3'b111, 3'b000);
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
